pipelined_rca: RTL and testbench

- Parametrised, pipelined successor to the combinational ripple-carry adder.
- Splits an N-bit ripple chain into CHUNK-bit segments with one register stage per segment, so wide adds meet timing.
- Adds add/subtract mode, carry-in, signed-overflow and zero flags, and a valid/ready handshake with backpressure.
- Intended for ALU/address paths that can tolerate multi-cycle latency.

---
 rtl/pipelined_rca.sv | 131 +++++++++++++
 tb/tb_pipelined_rca.sv | 202 ++++++++++++++++++++
 2 files changed

// File: rtl/pipelined_rca.sv
// Pipelined ripple-carry adder/subtractor: one register stage per CHUNK bits, valid/ready handshake.
// Optional saturation on signed overflow is enabled by defining PIPE_RCA_SAT_EN (adds the sat port).
module pipelined_rca #(
  parameter int N     = 32,
  parameter int CHUNK = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [N-1:0] a,
  input  logic [N-1:0] b,
  input  logic         cin,
  input  logic         sub,
`ifdef PIPE_RCA_SAT_EN
  input  logic         sat,
`endif
  output logic         out_valid,
  input  logic         out_ready,
  output logic [N:0]   sum,
  output logic         ovf,
  output logic         zero
);

  localparam int STAGES = (N + CHUNK - 1) / CHUNK;

  logic         adv;
  logic [N-1:0] opA_q   [STAGES];
  logic [N-1:0] opA_d   [STAGES];
  logic [N-1:0] opB_q   [STAGES];
  logic [N-1:0] opB_d   [STAGES];
  logic [N-1:0] part_q  [STAGES];
  logic [N-1:0] part_d  [STAGES];
  logic         carry_q [STAGES];
  logic         carry_d [STAGES];
  logic         valid_q [STAGES];
  logic         valid_d [STAGES];
`ifdef PIPE_RCA_SAT_EN
  logic         sat_q   [STAGES];
  logic         sat_d   [STAGES];
`endif
  logic         ovf_q, ovf_d;
  logic         zero_q, zero_d;

  // The whole pipe moves as one; a stalled output freezes every stage.
  assign adv       = !valid_q[STAGES-1] || out_ready;
  assign in_ready  = adv;
  assign out_valid = valid_q[STAGES-1];
  assign sum       = {carry_q[STAGES-1], part_q[STAGES-1]};
  assign ovf       = ovf_q;
  assign zero      = zero_q;

  // Stage k ripples its own chunk; untouched operand bits and finished sum bits ride along.
  always_comb begin
    logic [N-1:0] ai, bi, si;
    logic         ci, vi;
    int           p;
`ifdef PIPE_RCA_SAT_EN
    logic         sati;
    logic [N-1:0] clampV;
`endif
    ovf_d  = 1'b0;
    zero_d = 1'b0;
    for (int k = 0; k < STAGES; k++) begin
      p  = (k == 0) ? 0 : k - 1;
      ai = (k == 0) ? a : opA_q[p];
      bi = (k == 0) ? (sub ? ~b : b) : opB_q[p];
      ci = (k == 0) ? (sub ? 1'b1 : cin) : carry_q[p];
      si = (k == 0) ? '0 : part_q[p];
      vi = (k == 0) ? in_valid : valid_q[p];
`ifdef PIPE_RCA_SAT_EN
      sati = (k == 0) ? sat : sat_q[p];
`endif
      for (int i = 0; i < N; i++) begin
        if ((i / CHUNK) == k) begin
          si[i] = ai[i] ^ bi[i] ^ ci;
          ci    = (ai[i] & bi[i]) | (ci & (ai[i] ^ bi[i]));
        end
      end
      if (k == STAGES - 1) begin
        ovf_d = (ai[N-1] == bi[N-1]) && (si[N-1] != ai[N-1]);
`ifdef PIPE_RCA_SAT_EN
        // Clamp toward the extreme on the side the operands' sign points to; carry stays raw.
        clampV      = {N{~ai[N-1]}};
        clampV[N-1] = ai[N-1];
        if (sati && ovf_d) si = clampV;
`endif
        zero_d = (si == '0);
      end
      opA_d[k]   = ai;
      opB_d[k]   = bi;
      part_d[k]  = si;
      carry_d[k] = ci;
      valid_d[k] = vi;
`ifdef PIPE_RCA_SAT_EN
      sat_d[k]   = sati;
`endif
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 0; k < STAGES; k++) begin
        opA_q[k]   <= '0;
        opB_q[k]   <= '0;
        part_q[k]  <= '0;
        carry_q[k] <= 1'b0;
        valid_q[k] <= 1'b0;
`ifdef PIPE_RCA_SAT_EN
        sat_q[k]   <= 1'b0;
`endif
      end
      ovf_q  <= 1'b0;
      zero_q <= 1'b0;
    end else if (adv) begin
      for (int k = 0; k < STAGES; k++) begin
        opA_q[k]   <= opA_d[k];
        opB_q[k]   <= opB_d[k];
        part_q[k]  <= part_d[k];
        carry_q[k] <= carry_d[k];
        valid_q[k] <= valid_d[k];
`ifdef PIPE_RCA_SAT_EN
        sat_q[k]   <= sat_d[k];
`endif
      end
      ovf_q  <= ovf_d;
      zero_q <= zero_d;
    end
  end

endmodule

// File: tb/tb_pipelined_rca.sv
// Directed bench for pipelined_rca with N=8, CHUNK=4 (two-cycle latency).
// Saturation vectors are exercised only when PIPE_RCA_SAT_EN is defined.
module tb_pipelined_rca;

  logic       clk;
  logic       rst_n;
  logic       in_valid;
  logic       in_ready;
  logic [7:0] a;
  logic [7:0] b;
  logic       cin;
  logic       sub;
  logic       sat;
  logic       out_valid;
  logic       out_ready;
  logic [8:0] sum;
  logic       ovf;
  logic       zero;

  int checks = 0;
  int errors = 0;

  pipelined_rca #(.N(8), .CHUNK(4)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .cin       (cin),
    .sub       (sub),
`ifdef PIPE_RCA_SAT_EN
    .sat       (sat),
`endif
    .out_valid (out_valid),
    .out_ready (out_ready),
    .sum       (sum),
    .ovf       (ovf),
    .zero      (zero)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic applyStimulus(input logic v, input logic [7:0] av, input logic [7:0] bv,
                               input logic c, input logic s);
    in_valid = v;
    a        = av;
    b        = bv;
    cin      = c;
    sub      = s;
  endtask

  task automatic checkVal(input string tag, input logic [8:0] got, input logic [8:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("[TB] FAIL %s observed %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic checkOutput(input string tag, input logic ev, input logic [8:0] es,
                             input logic eo, input logic ez);
    checkVal({tag, " out_valid"}, 9'(out_valid), 9'(ev));
    if (ev) begin
      checkVal({tag, " sum"},  sum,        es);
      checkVal({tag, " ovf"},  9'(ovf),    9'(eo));
      checkVal({tag, " zero"}, 9'(zero),   9'(ez));
    end
  endtask

  // One isolated beat: nothing at t+1, result at t+2, bubble at t+3.
  task automatic sendOne(input string tag, input logic [7:0] av, input logic [7:0] bv,
                         input logic c, input logic s, input logic [8:0] es,
                         input logic eo, input logic ez);
    applyStimulus(1'b1, av, bv, c, s);
    tick();
    applyStimulus(1'b0, 8'h00, 8'h00, 1'b0, 1'b0);
    checkOutput({tag, " t+1"}, 1'b0, 9'h000, 1'b0, 1'b0);
    tick();
    checkOutput(tag, 1'b1, es, eo, ez);
    tick();
    checkOutput({tag, " t+3"}, 1'b0, 9'h000, 1'b0, 1'b0);
  endtask

  // Ten beats a=i, b=2i; out_ready drops for stallLen cycles starting at stallStart.
  task automatic runStream(input string tag, input int stallStart, input int stallLen);
    logic [8:0] expQ[$];
    int         sent     = 0;
    int         got      = 0;
    int         firstOut = -1;
    int         lastOut  = -1;
    logic       stalled;
    for (int cyc = 0; cyc < 40; cyc++) begin
      stalled   = (cyc >= stallStart) && (cyc < stallStart + stallLen);
      out_ready = !stalled;
      if (sent < 10) applyStimulus(1'b1, 8'(sent), 8'(2 * sent), 1'b0, 1'b0);
      else           applyStimulus(1'b0, 8'h00, 8'h00, 1'b0, 1'b0);
      #1;
      checkVal({tag, " in_ready"}, 9'(in_ready), 9'(!stalled));
      if (out_valid) begin
        if (expQ.size() == 0) begin
          checks++;
          errors++;
          $error("[TB] FAIL %s spurious out_valid observed sum %0h expected none", tag, sum);
        end else begin
          checkVal({tag, " sum"}, sum, expQ[0]);
          if (!stalled) begin
            void'(expQ.pop_front());
            got++;
            if (firstOut < 0) firstOut = cyc;
            lastOut = cyc;
          end
        end
      end
      if (in_valid && !stalled) begin
        expQ.push_back(9'(3 * sent));
        sent++;
      end
      tick();
    end
    out_ready = 1'b1;
    checkVal({tag, " beats out"}, 9'(got), 9'd10);
    checkVal({tag, " leftover"}, 9'(expQ.size()), 9'd0);
    if (stallLen == 0) checkVal({tag, " out span"}, 9'(lastOut - firstOut), 9'd9);
    else               checkVal({tag, " out span"}, 9'(lastOut - firstOut), 9'(9 + stallLen));
  endtask

  initial begin
    rst_n     = 1'b0;
    out_ready = 1'b1;
    sat       = 1'b0;
    applyStimulus(1'b0, 8'h00, 8'h00, 1'b0, 1'b0);
    #12;
    checkVal("reset out_valid", 9'(out_valid), 9'd0);
    checkVal("reset sum", sum, 9'h000);
    checkVal("reset ovf", 9'(ovf), 9'd0);
    checkVal("reset zero", 9'(zero), 9'd0);
    checkVal("reset in_ready", 9'(in_ready), 9'd1);
    tick();
    rst_n = 1'b1;
    tick();

    sendOne("0F+01",      8'h0F, 8'h01, 1'b0, 1'b0, 9'h010, 1'b0, 1'b0);
    sendOne("FF+01",      8'hFF, 8'h01, 1'b0, 1'b0, 9'h100, 1'b0, 1'b1);
    sendOne("7F+01",      8'h7F, 8'h01, 1'b0, 1'b0, 9'h080, 1'b1, 1'b0);
    sendOne("10+20+c",    8'h10, 8'h20, 1'b1, 1'b0, 9'h031, 1'b0, 1'b0);
    sendOne("80+FF",      8'h80, 8'hFF, 1'b0, 1'b0, 9'h17F, 1'b1, 1'b0);
    sendOne("05-05",      8'h05, 8'h05, 1'b0, 1'b1, 9'h100, 1'b0, 1'b1);
    sendOne("03-05",      8'h03, 8'h05, 1'b0, 1'b1, 9'h0FE, 1'b0, 1'b0);
    sendOne("08-03 cin",  8'h08, 8'h03, 1'b1, 1'b1, 9'h105, 1'b0, 1'b0);
    sendOne("80-01",      8'h80, 8'h01, 1'b0, 1'b1, 9'h17F, 1'b1, 1'b0);

    runStream("stream", 100, 0);
    runStream("stall",  5, 3);

    // Two beats in flight, output blocked, then async reset mid-cycle.
    out_ready = 1'b0;
    applyStimulus(1'b1, 8'h11, 8'h22, 1'b0, 1'b0);
    tick();
    applyStimulus(1'b1, 8'h33, 8'h44, 1'b0, 1'b0);
    tick();
    applyStimulus(1'b0, 8'h00, 8'h00, 1'b0, 1'b0);
    checkOutput("inflight", 1'b1, 9'h033, 1'b0, 1'b0);
    #2;
    rst_n = 1'b0;
    #1;
    checkVal("async out_valid", 9'(out_valid), 9'd0);
    checkVal("async sum", sum, 9'h000);
    checkVal("async ovf", 9'(ovf), 9'd0);
    checkVal("async zero", 9'(zero), 9'd0);
    checkVal("async in_ready", 9'(in_ready), 9'd1);
    tick();
    tick();
    rst_n     = 1'b1;
    out_ready = 1'b1;
    tick();
    checkOutput("post-reset idle", 1'b0, 9'h000, 1'b0, 1'b0);
    sendOne("post-reset 05+06", 8'h05, 8'h06, 1'b0, 1'b0, 9'h00B, 1'b0, 1'b0);
    tick();
    checkOutput("post-reset drained", 1'b0, 9'h000, 1'b0, 1'b0);

`ifdef PIPE_RCA_SAT_EN
    sat = 1'b1;
    sendOne("sat 7F+01", 8'h7F, 8'h01, 1'b0, 1'b0, 9'h07F, 1'b1, 1'b0);
    sendOne("sat 80+FF", 8'h80, 8'hFF, 1'b0, 1'b0, 9'h180, 1'b1, 1'b0);
    sendOne("sat 10+20", 8'h10, 8'h20, 1'b0, 1'b0, 9'h030, 1'b0, 1'b0);
    sat = 1'b0;
    sendOne("nosat 7F+01", 8'h7F, 8'h01, 1'b0, 1'b0, 9'h080, 1'b1, 1'b0);
    sendOne("nosat 80+FF", 8'h80, 8'hFF, 1'b0, 1'b0, 9'h17F, 1'b1, 1'b0);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
